// File: rtl/riscv_core_pkg.sv
// rtl/riscv_core_pkg.sv - shared types for the RV64M multiply sequencer
package riscv_core_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIX   = 3'd3,
    ST_RESP  = 3'd4,
    ST_DRAIN = 3'd5
  } mul_state_e;

  // Accept-to-result-valid cycles when the multiplier is actually used.
  localparam int MUL_LAT = 67;

endpackage

// File: rtl/riscv_core_mul_fix.sv
// rtl/riscv_core_mul_fix.sv - sign correction of the unsigned product and result half/word select
module riscv_core_mul_fix
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN-1:0] prod_i,
  input  logic              neg_i,
  input  mul_op_e           op_i,
  input  logic              word_i,
  output logic [XLEN-1:0]   res_o
);

  logic [2*XLEN-1:0] p;

  always_comb begin
    p     = neg_i ? (~prod_i + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_i;
    res_o = p[2*XLEN-1:XLEN];
    if (word_i) begin
      res_o = {{(XLEN-32){p[31]}}, p[31:0]};
    end else if (op_i == MUL_OP_MUL) begin
      res_o = p[XLEN-1:0];
    end
  end

endmodule

// File: rtl/riscv_core_mul_ctrl.sv
// rtl/riscv_core_mul_ctrl.sv - request/response sequencer around the 64-cycle shift-add multiplier
module riscv_core_mul_ctrl
  import riscv_core_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic              i_booth_clk,
  input  logic              i_booth_rstn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_op,
  input  logic              i_req_word,
  input  logic [XLEN-1:0]   i_req_rs1,
  input  logic [XLEN-1:0]   i_req_rs2,
  input  logic [TAG_W-1:0]  i_req_tag,
  input  logic              i_flush,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [XLEN-1:0]   o_res_data,
  output logic [TAG_W-1:0]  o_res_tag,
  output logic              o_busy,
  output logic [XLEN-1:0]   o_booth_multiplicand,
  output logic [XLEN-1:0]   o_booth_multiplier,
  output logic              o_booth_en,
  input  logic              i_booth_done,
  input  logic [2*XLEN-1:0] i_booth_product
);

  mul_state_e        state_q, state_d;
  mul_op_e           op_q, op_d;
  logic              word_q, word_d;
  logic              neg_q, neg_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   res_q, res_d;

  mul_op_e           req_op;
  logic              req_word;
  logic              sign1, sign2;
  logic [XLEN-1:0]   op1, op2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              mag_zero;
  logic              accept;
  logic [XLEN-1:0]   fix_res;

  // Operand preparation for the request currently presented.
  always_comb begin
    req_op   = mul_op_e'(i_req_op);
    req_word = i_req_word & (req_op == MUL_OP_MUL);
    sign1    = ((req_op == MUL_OP_MULH) | (req_op == MUL_OP_MULHSU)) & i_req_rs1[XLEN-1];
    sign2    = (req_op == MUL_OP_MULH) & i_req_rs2[XLEN-1];
    op1      = req_word ? {{(XLEN-32){1'b0}}, i_req_rs1[31:0]} : i_req_rs1;
    op2      = req_word ? {{(XLEN-32){1'b0}}, i_req_rs2[31:0]} : i_req_rs2;
    mag1     = sign1 ? (~op1 + {{(XLEN-1){1'b0}}, 1'b1}) : op1;
    mag2     = sign2 ? (~op2 + {{(XLEN-1){1'b0}}, 1'b1}) : op2;
    mag_zero = (mag1 == '0) | (mag2 == '0);
  end

  assign accept = i_req_valid & o_req_ready;

  riscv_core_mul_fix #(.XLEN(XLEN)) u_fix (
    .prod_i (prod_q),
    .neg_i  (neg_q),
    .op_i   (op_q),
    .word_i (word_q),
    .res_o  (fix_res)
  );

  always_ff @(posedge i_booth_clk or negedge i_booth_rstn) begin
    if (!i_booth_rstn) begin
      state_q  <= ST_IDLE;
      op_q     <= MUL_OP_MUL;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      tag_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      tag_q    <= tag_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = mag_zero ? ST_RESP : ST_START;
      ST_START: state_d = i_flush ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        // A flush coinciding with done has nothing left to drain.
        if (i_flush)           state_d = i_booth_done ? ST_IDLE : ST_DRAIN;
        else if (i_booth_done) state_d = ST_FIX;
      end
      ST_FIX:   state_d = i_flush ? ST_IDLE : ST_RESP;
      ST_RESP:  if (i_flush | i_res_ready) state_d = ST_IDLE;
      ST_DRAIN: if (i_booth_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    tag_d    = tag_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    res_d    = res_q;
    if ((state_q == ST_IDLE) && accept) begin
      op_d     = req_op;
      word_d   = req_word;
      neg_d    = sign1 ^ sign2;
      tag_d    = i_req_tag;
      mcand_d  = mag1;
      mplier_d = mag2;
      res_d    = '0;
    end
    if ((state_q == ST_WAIT) && i_booth_done && !i_flush) prod_d = i_booth_product;
    if ((state_q == ST_FIX) && !i_flush) res_d = fix_res;
  end

  always_comb begin
    o_req_ready = (state_q == ST_IDLE) & ~i_flush;
    o_busy      = (state_q != ST_IDLE);
    o_booth_en  = (state_q == ST_START);
    o_res_valid = (state_q == ST_RESP);
  end

  assign o_res_data           = res_q;
  assign o_res_tag            = tag_q;
  assign o_booth_multiplicand = mcand_q;
  assign o_booth_multiplier   = mplier_q;

endmodule

// File: tb/tb_riscv_core_mul_ctrl.sv
// tb/tb_riscv_core_mul_ctrl.sv - directed-vector bench with a behavioural 64-cycle multiplier
module tb_riscv_core_mul_ctrl;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_valid, req_ready, req_word, flush;
  logic [1:0]   req_op;
  logic [63:0]  rs1, rs2;
  logic [4:0]   req_tag;
  logic         res_valid, res_ready, busy, en, done;
  logic [63:0]  res_data, mcand, mplier;
  logic [4:0]   res_tag;
  logic [127:0] product;

  logic         m_busy;
  logic [6:0]   m_cnt;
  int           en_total = 0;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  riscv_core_mul_ctrl dut (
    .i_booth_clk          (clk),
    .i_booth_rstn         (rstn),
    .i_req_valid          (req_valid),
    .o_req_ready          (req_ready),
    .i_req_op             (req_op),
    .i_req_word           (req_word),
    .i_req_rs1            (rs1),
    .i_req_rs2            (rs2),
    .i_req_tag            (req_tag),
    .i_flush              (flush),
    .o_res_valid          (res_valid),
    .i_res_ready          (res_ready),
    .o_res_data           (res_data),
    .o_res_tag            (res_tag),
    .o_busy               (busy),
    .o_booth_multiplicand (mcand),
    .o_booth_multiplier   (mplier),
    .o_booth_en           (en),
    .i_booth_done         (done),
    .i_booth_product      (product)
  );

  // Multiplier stand-in: en seen at edge 2 yields done during cycle 65.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy  <= 1'b0;
      m_cnt   <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (en) begin
        m_busy <= 1'b1;
        m_cnt  <= '0;
      end else if (m_busy) begin
        if (m_cnt == 7'd62) begin
          done    <= 1'b1;
          m_busy  <= 1'b0;
          product <= {64'd0, mcand} * {64'd0, mplier};
        end
        m_cnt <= m_cnt + 7'd1;
      end
    end
  end

  always @(posedge clk) if (en) en_total <= en_total + 1;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, req_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_valid"}, res_valid, 1'b0);
    check({tag, "_en"}, en, 1'b0);
    check({tag, "_data"}, res_data, 64'd0);
    check({tag, "_tag"}, res_tag, 5'd0);
    check({tag, "_mcand"}, mcand, 64'd0);
    check({tag, "_mplier"}, mplier, 64'd0);
  endtask

  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tg);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_word = w; rs1 = a; rs2 = b; req_tag = tg;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_req(input string name, input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tg, input logic [63:0] exp,
                         input int exp_lat, input int exp_en, input int hold);
    int lat;
    int e0;
    logic bad;
    e0 = en_total;
    issue(op, w, a, b, tg);
    lat = 1;
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_data"}, res_data, exp);
    check({name, "_tag"}, res_tag, tg);
    check({name, "_en_pulses"}, en_total - e0, exp_en);
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = 2'd3; rs1 = 64'd7; rs2 = 64'd9; req_tag = ~tg;
      @(negedge clk);
      if (!res_valid || req_ready || res_data !== exp || res_tag !== tg) bad = 1'b1;
    end
    if (hold > 0) check({name, "_hold_stable"}, bad, 1'b0);
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({name, "_released"}, {res_valid, busy}, 2'b00);
  endtask

  initial begin
    int n;
    logic seen_v, seen_r;
    rstn = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_word = 1'b0; rs1 = '0; rs2 = '0;
    req_tag = '0; flush = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rstn = 1'b1;
    @(negedge clk);

    run_req("mulhu_max", 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3,
            64'hFFFF_FFFF_FFFF_FFFE, 67, 1, 0);
    run_req("mulh_m2x3", 2'd1, 1'b0, -64'sd2, 64'd3, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 67, 1, 0);
    run_req("mul_m2x3", 2'd0, 1'b0, -64'sd2, 64'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFFA, 67, 1, 0);
    run_req("mulh_min", 2'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd6,
            64'h4000_0000_0000_0000, 67, 1, 0);
    run_req("mulhsu_m1x2", 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7,
            64'hFFFF_FFFF_FFFF_FFFF, 67, 1, 0);
    run_req("mulw", 2'd0, 1'b1, 64'h1_0000_FFFF, 64'd2, 5'd8, 64'h0000_0000_0001_FFFE, 67, 1, 0);
    run_req("mulw_sext", 2'd0, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 5'd9,
            64'hFFFF_FFFF_FFFF_FFFE, 67, 1, 0);
    run_req("mul_zero", 2'd0, 1'b0, 64'h1234, 64'd0, 5'd10, 64'd0, 1, 0, 0);
    run_req("mulh_zero", 2'd1, 1'b0, -64'sd5, 64'd0, 5'd11, 64'd0, 1, 0, 0);
    run_req("backpressure", 2'd3, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 5'd12, 64'd1, 67, 1, 10);

    // Flush while the multiplier is running: drain, then idle with no result.
    issue(2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 5'd13);
    n = 1;
    while (n < 30) begin @(negedge clk); n++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n++;
    seen_v = 1'b0; seen_r = 1'b0;
    while (busy && n < 200) begin
      if (res_valid) seen_v = 1'b1;
      if (req_ready) seen_r = 1'b1;
      @(negedge clk);
      n++;
    end
    check("flush_no_valid", seen_v, 1'b0);
    check("flush_ready_low", seen_r, 1'b0);
    check("flush_idle_cycle", n, 66);
    run_req("after_flush", 2'd3, 1'b0, 64'h2_0000_0000, 64'h3_0000_0000, 5'd14, 64'd6, 67, 1, 0);

    // Flush while the result is presented.
    issue(2'd0, 1'b0, 64'd5, 64'd0, 5'd15);
    check("resp_valid_before_flush", res_valid, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("resp_flush_drop", {res_valid, busy}, 2'b00);

    // A request alongside flush in IDLE is ignored.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd3; rs1 = 64'd3; rs2 = 64'd3;
    flush = 1'b1;
    #1 check("idle_flush_ready", req_ready, 1'b0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("idle_flush_ignored", busy, 1'b0);

    // Asynchronous reset in the middle of an operation.
    issue(2'd1, 1'b0, 64'd9, 64'd9, 5'd16);
    n = 1;
    while (n < 40) begin @(negedge clk); n++; end
    rstn = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_req("after_reset", 2'd0, 1'b0, 64'd1000, 64'd1000, 5'd17, 64'd1000000, 67, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
